// File: rtl/ins_issue_sequencer.sv
// ins_issue_sequencer: fetches instructions from ROM and issues them to dependency check.
// Inserts one bubble on a load-use hazard and handles start, hold and HALT.
module ins_issue_sequencer #(
    parameter int         PC_W    = 8,
    parameter logic [4:0] OP_LOAD = 5'b10100,
    parameter logic [4:0] OP_HALT = 5'b11111
) (
    input  logic            Clkk,
    input  logic            Rstn,
    input  logic            start,
    input  logic            hold,
    input  logic [19:0]     Ins,
    output logic [PC_W-1:0] pc,
    output logic            fetch_en,
    output logic [19:0]     Ins_out,
    output logic            issue_valid,
    output logic            stall,
    output logic            halted,
    output logic [7:0]      stall_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
    state_t state, state_nx;
    // Only op and destination of the instruction in execute matter for hazard detection.
    logic [9:0]      ex, ex_nx;
    logic [19:0]     ins_out_nx;
    logic [PC_W-1:0] pc_nx;
    logic            iv_nx, halted_nx, active, hazard;
    logic [7:0]      cnt_nx;
    assign active   = state == RUN && !hold;
    assign hazard   = ex[9:5] == OP_LOAD && ex[4:0] != 5'd0 &&
                      (ex[4:0] == Ins[9:5] || ex[4:0] == Ins[4:0]);
    assign fetch_en = active;
    assign stall    = active && hazard;
    always_ff @(posedge Clkk or negedge Rstn) begin
        if (!Rstn) begin
            state       <= IDLE;
            pc          <= '0;
            ex          <= '0;
            Ins_out     <= '0;
            issue_valid <= 1'b0;
            halted      <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            ex          <= ex_nx;
            Ins_out     <= ins_out_nx;
            issue_valid <= iv_nx;
            halted      <= halted_nx;
            stall_cnt   <= cnt_nx;
        end
    end
    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        ex_nx      = ex;
        ins_out_nx = Ins_out;
        iv_nx      = issue_valid;
        halted_nx  = halted;
        cnt_nx     = stall_cnt;
        if (state == IDLE && start) begin
            state_nx = RUN;
            pc_nx    = '0;
        end else if (stall) begin
            ins_out_nx = '0;
            iv_nx      = 1'b0;
            ex_nx      = '0;
            cnt_nx     = &stall_cnt ? stall_cnt : stall_cnt + 8'd1;
        end else if (active && Ins[19:15] == OP_HALT) begin
            ins_out_nx = '0;
            iv_nx      = 1'b0;
            ex_nx      = '0;
            state_nx   = HALTED;
            halted_nx  = 1'b1;
        end else if (active) begin
            ins_out_nx = Ins;
            iv_nx      = 1'b1;
            ex_nx      = Ins[19:10];
            pc_nx      = pc + 1'b1;
        end
    end
endmodule

// File: tb/tb_ins_issue_sequencer.sv
// tb_ins_issue_sequencer: directed and random stimulus against a spec-level model.
module tb_ins_issue_sequencer;
    localparam int         PC_W = 2;
    localparam logic [4:0] LD   = 5'b10100;
    localparam logic [4:0] HLT  = 5'b11111;

    logic            Clkk = 1'b0, Rstn = 1'b0, start = 1'b0, hold = 1'b0;
    logic [19:0]     Ins, Ins_out;
    logic [PC_W-1:0] pc;
    logic            fetch_en, issue_valid, stall, halted;
    logic [7:0]      stall_cnt;
    logic [19:0]     rom [4];

    int assert_cnt = 0, fail_cnt = 0;
    // Model: 0 idle, 1 run, 2 halted; m_ld is the destination of a just-issued load (0 if none).
    int          m_state, m_pc, m_cnt, m_ld;
    logic [19:0] m_out;
    bit          m_iv, m_halt;

    ins_issue_sequencer #(.PC_W(PC_W), .OP_LOAD(LD), .OP_HALT(HLT)) dut (
        .Clkk(Clkk), .Rstn(Rstn), .start(start), .hold(hold), .Ins(Ins), .pc(pc),
        .fetch_en(fetch_en), .Ins_out(Ins_out), .issue_valid(issue_valid),
        .stall(stall), .halted(halted), .stall_cnt(stall_cnt));

    assign Ins = rom[pc];
    always #5 Clkk = ~Clkk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] mk(input logic [4:0] op, rw, ra, rb);
        return {op, rw, ra, rb};
    endfunction

    task automatic model_reset();
        m_state = 0; m_pc = 0; m_cnt = 0; m_ld = 0; m_out = '0; m_iv = 0; m_halt = 0;
    endtask

    task automatic check_regs();
        check("pc", 32'(pc), 32'(m_pc));
        check("ins_out", 32'(Ins_out), 32'(m_out));
        check("issue_valid", 32'(issue_valid), 32'(m_iv));
        check("halted", 32'(halted), 32'(m_halt));
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    endtask

    // One clock cycle: drive, check away from the edge, then advance the model across the edge.
    task automatic cyc(input logic st, input logic hd);
        logic [19:0] i;
        bit run, haz;
        start = st; hold = hd;
        #4;
        i   = rom[m_pc];
        run = m_state == 1 && !hd;
        haz = m_ld != 0 && (m_ld == int'(i[9:5]) || m_ld == int'(i[4:0]));
        check_regs();
        check("fetch_en", 32'(fetch_en), 32'(run));
        check("stall", 32'(stall), 32'(run && haz));
        @(posedge Clkk);
        if (m_state == 0 && st) begin
            m_state = 1; m_pc = 0;
        end else if (run && haz) begin
            m_out = '0; m_iv = 0; m_ld = 0; m_cnt = m_cnt < 255 ? m_cnt + 1 : 255;
        end else if (run && i[19:15] == HLT) begin
            m_out = '0; m_iv = 0; m_ld = 0; m_state = 2; m_halt = 1;
        end else if (run) begin
            m_out = i; m_iv = 1; m_pc = (m_pc + 1) % 4;
            m_ld = i[19:15] == LD ? int'(i[14:10]) : 0;
        end
        #1;
    endtask

    task automatic async_reset();
        Rstn = 1'b0;
        #1;
        model_reset();
        check_regs();
        check("rst_stall", 32'(stall), 32'(0));
        @(posedge Clkk);
        #1;
        Rstn = 1'b1;
    endtask

    function automatic logic [19:0] rnd_ins();
        int r = $urandom_range(0, 19);
        logic [4:0] op = r < 1 ? HLT : r < 9 ? LD : 5'($urandom_range(0, 30));
        return mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    endfunction

    initial begin
        model_reset();
        @(posedge Clkk);
        #1;
        async_reset();
        // plain issue, no hazards
        rom = '{20'b00000000010001000011, 20'b00100001010000100100, mk(0, 1, 2, 3), mk(0, 3, 2, 1)};
        cyc(1, 0);
        repeat (5) cyc(0, 0);
        // load r2 then reader of r2
        async_reset();
        rom = '{mk(LD, 2, 1, 0), mk(5'b01101, 3, 2, 5), mk(0, 1, 1, 1), mk(0, 1, 1, 1)};
        cyc(1, 0);
        repeat (5) cyc(0, 0);
        // load r0 then reader of r0
        async_reset();
        rom = '{mk(LD, 0, 1, 1), mk(1, 3, 0, 0), mk(0, 1, 2, 3), mk(0, 1, 2, 3)};
        cyc(1, 0);
        repeat (5) cyc(0, 0);
        // hold across the hazard cycle
        async_reset();
        rom = '{mk(LD, 2, 1, 0), mk(5'b01101, 3, 2, 5), mk(0, 1, 1, 1), mk(0, 1, 1, 1)};
        cyc(1, 0);
        cyc(0, 0);
        repeat (3) cyc(0, 1);
        repeat (3) cyc(0, 0);
        // HALT at address 3, start ignored afterwards
        async_reset();
        rom = '{mk(0, 1, 2, 3), mk(2, 2, 3, 1), mk(3, 3, 1, 2), mk(HLT, 0, 0, 0)};
        cyc(1, 0);
        repeat (5) cyc(0, 0);
        cyc(1, 0);
        repeat (2) cyc(0, 0);
        // asynchronous reset between edges during a stall
        async_reset();
        rom = '{mk(LD, 2, 1, 0), mk(5'b01101, 3, 2, 5), mk(0, 1, 1, 1), mk(0, 1, 1, 1)};
        cyc(1, 0);
        repeat (6) cyc(0, 0);
        start = 1'b0; hold = 1'b0;
        #2;
        check("mid_stall", 32'(stall), 32'(1));
        async_reset();
        // pc wrap 3 -> 0
        rom = '{mk(0, 1, 2, 3), mk(2, 2, 3, 1), mk(3, 3, 1, 2), mk(4, 1, 1, 1)};
        cyc(1, 0);
        repeat (7) cyc(0, 0);
        // back-to-back load-uses drive stall_cnt into saturation
        async_reset();
        rom = '{mk(LD, 1, 1, 1), mk(LD, 1, 1, 1), mk(LD, 1, 1, 1), mk(LD, 1, 1, 1)};
        cyc(1, 0);
        repeat (540) cyc(0, 0);
        check("stall_cnt_sat", 32'(stall_cnt), 32'(255));
        // randomized runs
        for (int r = 0; r < 12; r++) begin
            async_reset();
            for (int a = 0; a < 4; a++) rom[a] = rnd_ins();
            cyc(1, 0);
            for (int c = 0; c < 60; c++) cyc($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule
